median_stream_filter: RTL and testbench
=======================================

// Module: median_stream_filter
// PURPOSE
//  Streaming 3x3 rank filter for the camera pixel path; sits between capture and motion-detect logic.
//  Holds two line buffers and a 3x3 window, then sorts each channel independently in a pipelined network.
//  Outputs median, min, max or bypass per frame. One result per accepted input pixel at fixed latency.
// PARAMETERS
//  DATA_W   8    bits per colour channel, unsigned
//  NUM_CH   3    channels packed MSB-first in a pixel word (ch NUM_CH-1 = R at top)
//  IMG_W    640  max active pixels per line (line buffer depth); >= 3
// PORTS
//  clk       in   1               single clock, all logic rising-edge
//  reset     in   1               synchronous, active-high
//  mode      in   2               0 bypass, 1 median, 2 min, 3 max; sampled on accepted in_sof pixel
//  in_valid  in   1               pixel qualifier; no backpressure, gaps allowed
//  in_sof    in   1               first pixel of frame (valid only with in_valid)
//  in_eol    in   1               last pixel of line (valid only with in_valid)
//  in_data   in   NUM_CH*DATA_W   pixel
//  out_valid out  1               result qualifier
//  out_sof   out  1               in_sof delayed with its pixel
//  out_eol   out  1               in_eol delayed with its pixel
//  out_data  out  NUM_CH*DATA_W   filtered pixel
//  line_err  out  1               1-cycle pulse: x reached IMG_W-1 without in_eol
// BEHAVIOUR
//  Reset: out_valid/out_sof/out_eol/line_err=0, out_data=0, x=y=0, active mode=1, window valid flags cleared.
//   Line buffer RAM contents are not reset; incomplete-window rule below masks them.
//  Counters (advance only on in_valid): in_sof forces this pixel to x=0,y=0 (restart mid-frame allowed).
//   After pixel: in_eol or x==IMG_W-1 -> x=0, y=y+1 (y saturates at 2^16-1); else x=x+1.
//   x==IMG_W-1 with in_eol=0 -> line_err pulse at LATENCY, x wraps anyway.
//  Window: on in_valid, columns shift left; new right column = {linebuf1[x], linebuf0[x], in_data};
//   linebuf1[x]<=linebuf0[x], linebuf0[x]<=in_data. Window bottom-right = current pixel, centre = (x-1,y-1).
//   Window columns reset to empty at x==0 (no horizontal bleed across lines).
//  Incomplete window (x<2 or y<2): out_data = current input pixel, regardless of mode.
//  Ranking: per channel, unsigned compare of 9 values; median = rank 4 (0-based ascending),
//   min = rank 0, max = rank 8. Channels never mixed. Ties: equal values, result unambiguous.
//  Bypass: out_data = in_data delayed LATENCY.
//  Pipeline, LATENCY = 4 cycles, fixed, valid-independent:
//   S1 window+tap register; S2 first half of sort network; S3 second half; S4 mode select -> outputs.
//   Each stage carries valid/sof/eol/incomplete/err/mode; stages advance every cycle, bubbles flow as out_valid=0.
//   Input accepted at cycle t -> out_valid=1 at t+4. Back-to-back inputs -> back-to-back outputs.
//  Mode: latched at accepted in_sof; travels with pixels, so a change never splits a frame.
//  Reset mid-frame: pipeline flushed (out_valid=0 next cycle); first frame after reset needs in_sof.
//  Simultaneous in_sof+in_eol: x=0 pixel, then y=1 line start (1-pixel line).
// TESTING
//  1) IMG_W=8, 4x8 frame all 0x405060, mode=1 -> every out_data=0x405060, 32 out_valid, first at t+4.
//  2) Mode=1, uniform 0x10 with single 0xFF pixel at (4,2) -> all complete-window outputs 0x10 (impulse removed).
//  3) Mode=2/3, R=x*10+y*3 ramp -> out R = value at (x-2,y-2) / (x,y); G,B unaffected.
//  4) in_valid toggling 1,0,1,0 with mode=1 -> outputs identical to gapless run, same spacing, latency 4.
//  5) Rows y=0,1 and cols x=0,1 -> out_data equals in_data; mode=0 whole frame -> out_data==in_data.
//  6) reset asserted mid-line 2 -> outputs 0 next cycle; in_eol missing at x=7 -> line_err pulse, x wraps.

Source files
------------

// File: rtl/median_stream_filter_if.sv
// median_stream_filter_if: pixel stream bundle shared by the filter input and output
//   valid : pixel qualifier
//   sof   : first pixel of frame
//   eol   : last pixel of line
//   data  : pixel word, W bits
//   master drives the stream, slave receives it
interface median_stream_filter_if #(parameter int W = 24);
   logic         valid;
   logic         sof;
   logic         eol;
   logic [W-1:0] data;
   modport master(output valid, sof, eol, data);
   modport slave(input valid, sof, eol, data);
endinterface

// File: rtl/median_stream_filter.sv
// median_stream_filter: streaming 3x3 per-channel median/min/max/bypass filter, fixed latency 4
//   clk      : single rising-edge clock
//   reset    : synchronous active-high reset
//   mode     : 0 bypass, 1 median, 2 min, 3 max; latched on the accepted sof pixel
//   in_s     : input stream (valid/sof/eol/data), no backpressure, gaps allowed
//   out_m    : filtered stream, one result per accepted input pixel
//   line_err : 1-cycle pulse with the pixel that reached IMG_W-1 without eol
module median_stream_filter #(
   parameter int DATA_W = 8,
   parameter int NUM_CH = 3,
   parameter int IMG_W  = 640
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic [1:0]             mode,
   median_stream_filter_if.slave  in_s,
   median_stream_filter_if.master out_m,
   output logic                   line_err
);
   localparam int PW = NUM_CH * DATA_W;
   localparam int XW = $clog2(IMG_W);
   typedef logic [DATA_W-1:0] ch_t;
   typedef logic [PW-1:0] pix_t;
   typedef struct packed {
      logic       v, sof, eol, inc, err;
      logic [1:0] mode;
   } ctl_t;
   function automatic ch_t mn2(ch_t a, ch_t b);
      return a < b ? a : b;
   endfunction
   function automatic ch_t mx2(ch_t a, ch_t b);
      return a < b ? b : a;
   endfunction
   function automatic ch_t md3(ch_t a, ch_t b, ch_t c);
      return mx2(mn2(a, b), mn2(mx2(a, b), c));
   endfunction
   function automatic ch_t chn(pix_t p, int k);
      return p[k*DATA_W +: DATA_W];
   endfunction
   logic [XW-1:0] x, cur_x;
   logic [15:0]   y, cur_y;
   logic [1:0]    mode_r, cur_mode;
   logic          last_x;
   pix_t          din;
   pix_t          lb0 [IMG_W];
   pix_t          lb1 [IMG_W];
   pix_t          col [3][3];
   ctl_t          c1, c2, c3;
   pix_t          t1, t2, t3, sel;
   ch_t           lo [NUM_CH][3];
   ch_t           md [NUM_CH][3];
   ch_t           hi [NUM_CH][3];
   ch_t           r_mn [NUM_CH];
   ch_t           r_md [NUM_CH];
   ch_t           r_mx [NUM_CH];
   // sof restarts position and picks up a new mode on the same pixel
   assign din      = in_s.data;
   assign cur_x    = in_s.sof ? '0 : x;
   assign cur_y    = in_s.sof ? '0 : y;
   assign cur_mode = in_s.sof ? mode : mode_r;
   assign last_x   = cur_x == XW'(IMG_W - 1);
   // col[column oldest..newest][row top..bottom]; columns empty at line start
   always_ff @(posedge clk)
      if (reset) begin
         x           <= '0;
         y           <= '0;
         mode_r      <= 2'd1;
         c1          <= '0;
         c2          <= '0;
         c3          <= '0;
         col         <= '{default: '0};
         out_m.valid <= 1'b0;
         out_m.sof   <= 1'b0;
         out_m.eol   <= 1'b0;
         out_m.data  <= '0;
         line_err    <= 1'b0;
      end else begin
         c1          <= in_s.valid ? ctl_t'{1'b1, in_s.sof, in_s.eol, cur_x < XW'(2) || cur_y < 16'd2,
                                            last_x && !in_s.eol, cur_mode} : ctl_t'('0);
         c2          <= c1;
         c3          <= c2;
         out_m.valid <= c3.v;
         out_m.sof   <= c3.sof;
         out_m.eol   <= c3.eol;
         out_m.data  <= sel;
         line_err    <= c3.err;
         if (in_s.valid) begin
            x      <= in_s.eol || last_x ? '0 : cur_x + 1'b1;
            y      <= in_s.eol || last_x ? (&cur_y ? cur_y : cur_y + 16'd1) : cur_y;
            mode_r <= cur_mode;
            for (int r = 0; r < 3; r++) begin
               col[0][r] <= cur_x == '0 ? '0 : col[1][r];
               col[1][r] <= cur_x == '0 ? '0 : col[2][r];
            end
            col[2] <= '{lb1[cur_x], lb0[cur_x], din};
         end
      end
   // Median of 9: sort each column, then median of (max of lows, median of mids, min of highs)
   always_ff @(posedge clk) begin
      if (in_s.valid) begin
         lb1[cur_x] <= lb0[cur_x];
         lb0[cur_x] <= din;
      end
      t1 <= din;
      t2 <= t1;
      t3 <= t2;
      for (int k = 0; k < NUM_CH; k++) begin
         for (int c = 0; c < 3; c++) begin
            lo[k][c] <= mn2(mn2(chn(col[c][0], k), chn(col[c][1], k)), chn(col[c][2], k));
            md[k][c] <= md3(chn(col[c][0], k), chn(col[c][1], k), chn(col[c][2], k));
            hi[k][c] <= mx2(mx2(chn(col[c][0], k), chn(col[c][1], k)), chn(col[c][2], k));
         end
         r_mn[k] <= mn2(mn2(lo[k][0], lo[k][1]), lo[k][2]);
         r_mx[k] <= mx2(mx2(hi[k][0], hi[k][1]), hi[k][2]);
         r_md[k] <= md3(mx2(mx2(lo[k][0], lo[k][1]), lo[k][2]), md3(md[k][0], md[k][1], md[k][2]),
                        mn2(mn2(hi[k][0], hi[k][1]), hi[k][2]));
      end
   end
   // Incomplete windows and bypass pass the tapped input pixel through
   always_comb begin
      sel = '0;
      for (int k = 0; k < NUM_CH; k++)
         sel[k*DATA_W +: DATA_W] = c3.inc || c3.mode == 2'd0 ? chn(t3, k) :
                                   c3.mode == 2'd2 ? r_mn[k] : c3.mode == 2'd3 ? r_mx[k] : r_md[k];
   end
endmodule

// File: tb/tb_median_stream_filter.sv
// tb_median_stream_filter: directed self-checking bench for median_stream_filter (IMG_W=8)
module tb_median_stream_filter;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] mode = 2'd1;
   logic       line_err;
   int         cyc = 0;
   int         n_cmp = 0;
   int         n_bad = 0;
   typedef struct {
      int          cyc;
      logic [23:0] d;
      logic        sof, eol;
   } obs_t;
   obs_t        mon_q [$];
   int          in_cyc [$];
   int          err_q [$];
   logic [23:0] img [4][8];
   logic [23:0] exp_d;

   median_stream_filter_if #(.W(24)) in_if ();
   median_stream_filter_if #(.W(24)) out_if ();

   median_stream_filter #(.DATA_W(8), .NUM_CH(3), .IMG_W(8)) dut (
      .clk(clk), .reset(reset), .mode(mode), .in_s(in_if), .out_m(out_if), .line_err(line_err)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;
   always @(negedge clk) begin
      if (out_if.valid === 1'b1) mon_q.push_back('{cyc, out_if.data, out_if.sof, out_if.eol});
      if (line_err === 1'b1) err_q.push_back(cyc);
   end

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic logic [23:0] rp(int x, int y);
      return {8'(x * 10 + y * 3), 8'h22, 8'h33};
   endfunction

   task automatic idle(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic put(input logic s, input logic e, input logic [23:0] d);
      in_if.valid = 1'b1;
      in_if.sof   = s;
      in_if.eol   = e;
      in_if.data  = d;
      in_cyc.push_back(cyc);
      @(negedge clk);
      in_if.valid = 1'b0;
      in_if.sof   = 1'b0;
      in_if.eol   = 1'b0;
   endtask

   // mode is changed right after the sof pixel to prove it is latched per frame
   task automatic send_frame(input logic [1:0] m, input int gap, input int rows, input bit eol_en);
      mon_q.delete();
      in_cyc.delete();
      err_q.delete();
      for (int y = 0; y < rows; y++)
         for (int x = 0; x < 8; x++) begin
            mode = (x == 0 && y == 0) ? m : m ^ 2'b11;
            put(x == 0 && y == 0, eol_en && x == 7, img[y][x]);
            idle(gap);
         end
      idle(8);
   endtask

   task automatic fill_const(input logic [23:0] v);
      for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) img[y][x] = v;
   endtask

   task automatic fill_ramp;
      for (int y = 0; y < 4; y++) for (int x = 0; x < 8; x++) img[y][x] = rp(x, y);
   endtask

   task automatic test_reset;
      reset = 1'b1;
      idle(3);
      n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", out_if.valid); end
      n_cmp++; if (out_if.sof !== 1'b0) begin n_bad++; $display("FAIL reset_sof got %b want 0", out_if.sof); end
      n_cmp++; if (out_if.eol !== 1'b0) begin n_bad++; $display("FAIL reset_eol got %b want 0", out_if.eol); end
      n_cmp++; if (out_if.data !== 24'h0) begin n_bad++; $display("FAIL reset_data got %h want 0", out_if.data); end
      n_cmp++; if (line_err !== 1'b0) begin n_bad++; $display("FAIL reset_line_err got %b want 0", line_err); end
      reset = 1'b0;
      idle(1);
   endtask

   task automatic test_uniform;
      fill_const(24'h405060);
      send_frame(2'd1, 0, 4, 1'b1);
      n_cmp++; if (mon_q.size() !== 32) begin n_bad++; $display("FAIL uniform_count got %0d want 32", mon_q.size()); end
      n_cmp++; if (err_q.size() !== 0) begin n_bad++; $display("FAIL uniform_no_err got %0d pulses want 0", err_q.size()); end
      for (int i = 0; i < mon_q.size() && i < 32; i++) begin
         n_cmp++;
         if (mon_q[i].d !== 24'h405060 || mon_q[i].cyc !== in_cyc[i] + 4 || mon_q[i].sof !== (i == 0) || mon_q[i].eol !== (i % 8 == 7)) begin
            n_bad++;
            $display("FAIL uniform px%0d got d=%h lat=%0d sof=%b eol=%b want d=405060 lat=4 sof=%b eol=%b",
                     i, mon_q[i].d, mon_q[i].cyc - in_cyc[i], mon_q[i].sof, mon_q[i].eol, i == 0, i % 8 == 7);
         end
      end
   endtask

   task automatic test_impulse;
      fill_const(24'h101010);
      img[2][4] = 24'hFFFFFF;
      send_frame(2'd1, 0, 4, 1'b1);
      n_cmp++; if (mon_q.size() !== 32) begin n_bad++; $display("FAIL impulse_count got %0d want 32", mon_q.size()); end
      for (int i = 0; i < mon_q.size() && i < 32; i++) begin
         n_cmp++;
         if (mon_q[i].d !== 24'h101010) begin
            n_bad++; $display("FAIL impulse px(%0d,%0d) got %h want 101010", i % 8, i / 8, mon_q[i].d);
         end
      end
   endtask

   task automatic test_min_max;
      fill_ramp;
      for (int m = 2; m <= 3; m++) begin
         send_frame(2'(m), 0, 4, 1'b1);
         n_cmp++; if (mon_q.size() !== 32) begin n_bad++; $display("FAIL minmax%0d_count got %0d want 32", m, mon_q.size()); end
         for (int i = 0; i < mon_q.size() && i < 32; i++) begin
            exp_d = (i % 8 < 2 || i / 8 < 2) ? rp(i % 8, i / 8) : (m == 2 ? rp(i % 8 - 2, i / 8 - 2) : rp(i % 8, i / 8));
            n_cmp++;
            if (mon_q[i].d !== exp_d) begin
               n_bad++; $display("FAIL minmax%0d px(%0d,%0d) got %h want %h", m, i % 8, i / 8, mon_q[i].d, exp_d);
            end
         end
      end
   endtask

   task automatic test_gaps;
      fill_ramp;
      send_frame(2'd1, 1, 4, 1'b1);
      n_cmp++; if (mon_q.size() !== 32) begin n_bad++; $display("FAIL gaps_count got %0d want 32", mon_q.size()); end
      for (int i = 0; i < mon_q.size() && i < 32; i++) begin
         exp_d = (i % 8 < 2 || i / 8 < 2) ? rp(i % 8, i / 8) : rp(i % 8 - 1, i / 8 - 1);
         n_cmp++;
         if (mon_q[i].d !== exp_d || mon_q[i].cyc !== in_cyc[i] + 4 || mon_q[i].sof !== (i == 0) || mon_q[i].eol !== (i % 8 == 7)) begin
            n_bad++;
            $display("FAIL gaps px(%0d,%0d) got d=%h lat=%0d sof=%b eol=%b want d=%h lat=4",
                     i % 8, i / 8, mon_q[i].d, mon_q[i].cyc - in_cyc[i], mon_q[i].sof, mon_q[i].eol, exp_d);
         end
      end
   endtask

   task automatic test_bypass;
      fill_const(24'h101010);
      img[2][4] = 24'hFFFFFF;
      img[3][6] = 24'h00FF00;
      send_frame(2'd0, 0, 4, 1'b1);
      n_cmp++; if (mon_q.size() !== 32) begin n_bad++; $display("FAIL bypass_count got %0d want 32", mon_q.size()); end
      for (int i = 0; i < mon_q.size() && i < 32; i++) begin
         n_cmp++;
         if (mon_q[i].d !== img[i / 8][i % 8]) begin
            n_bad++; $display("FAIL bypass px(%0d,%0d) got %h want %h", i % 8, i / 8, mon_q[i].d, img[i / 8][i % 8]);
         end
      end
   endtask

   task automatic test_reset_mid_line;
      mode = 2'd1;
      for (int y = 0; y < 2; y++) for (int x = 0; x < 8; x++) put(x == 0 && y == 0, x == 7, rp(x, y));
      for (int x = 0; x < 3; x++) put(1'b0, 1'b0, rp(x, 2));
      reset = 1'b1;
      @(negedge clk);
      n_cmp++; if (out_if.valid !== 1'b0) begin n_bad++; $display("FAIL midreset_valid got %b want 0", out_if.valid); end
      n_cmp++; if (out_if.data !== 24'h0) begin n_bad++; $display("FAIL midreset_data got %h want 0", out_if.data); end
      mon_q.delete();
      idle(2);
      reset = 1'b0;
      idle(8);
      n_cmp++; if (mon_q.size() !== 0) begin n_bad++; $display("FAIL midreset_flush got %0d outputs want 0", mon_q.size()); end
   endtask

   task automatic test_line_err;
      fill_ramp;
      send_frame(2'd2, 0, 3, 1'b0);
      n_cmp++; if (mon_q.size() !== 24) begin n_bad++; $display("FAIL lerr_count got %0d want 24", mon_q.size()); end
      n_cmp++; if (err_q.size() !== 3) begin n_bad++; $display("FAIL lerr_pulses got %0d want 3", err_q.size()); end
      for (int j = 0; j < err_q.size() && j < 3; j++) begin
         n_cmp++;
         if (err_q[j] !== in_cyc[j * 8 + 7] + 4) begin
            n_bad++; $display("FAIL lerr_time%0d got cyc %0d want %0d", j, err_q[j], in_cyc[j * 8 + 7] + 4);
         end
      end
      for (int i = 0; i < mon_q.size() && i < 24; i++) begin
         exp_d = (i % 8 < 2 || i / 8 < 2) ? rp(i % 8, i / 8) : rp(i % 8 - 2, i / 8 - 2);
         n_cmp++;
         if (mon_q[i].d !== exp_d) begin
            n_bad++; $display("FAIL lerr_wrap px(%0d,%0d) got %h want %h", i % 8, i / 8, mon_q[i].d, exp_d);
         end
      end
   endtask

   initial begin
      in_if.valid = 1'b0;
      in_if.sof   = 1'b0;
      in_if.eol   = 1'b0;
      in_if.data  = '0;
      @(negedge clk);
      test_reset;
      test_uniform;
      test_impulse;
      test_min_max;
      test_gaps;
      test_bypass;
      test_reset_mid_line;
      test_line_err;
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
